path_receiver: RTL and testbench

//  Consumer end of the maze solver's path-output handshake. After the solver flags the goal
//  (the_end), this block raises run, captures each cell strobed by load into a local buffer,
//  and on the solver's done replays the stored path downstream over a valid/ready stream.

---
 rtl/path_receiver_pkg.sv | 21 ++
 rtl/path_receiver_if.sv | 13 +
 rtl/path_receiver_buffer.sv | 27 ++
 rtl/path_receiver.sv | 116 +++++++++++
 tb/tb_path_receiver.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/path_receiver_pkg.sv
// Shared types and sizes for the maze path receiver: cell layout, default depth,
// and the receiver state encoding.
package path_receiver_pkg;

   localparam int COORD_W   = 4;
   localparam int CELL_W    = 2 * COORD_W;
   localparam int DEPTH_DEF = 256;

   typedef struct packed {
      logic [COORD_W-1:0] row;
      logic [COORD_W-1:0] col;
   } cell_t;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_REQ     = 2'd1,
      ST_COLLECT = 2'd2,
      ST_DRAIN   = 2'd3
   } rx_state_t;

endpackage

// File: rtl/path_receiver_if.sv
// Replay stream from the path receiver to the display/UART path-output logic.
interface path_receiver_if;
   import path_receiver_pkg::*;

   logic  out_valid;
   logic  out_ready;
   cell_t out_cell;
   logic  out_last;

   modport master (output out_valid, output out_cell, output out_last, input out_ready);
   modport slave  (input out_valid, input out_cell, input out_last, output out_ready);

endinterface

// File: rtl/path_receiver_buffer.sv
// Path storage: register array with synchronous write and asynchronous read.
// Contents are not reset; pointers in the receiver decide what is valid.
module path_receiver_buffer
   import path_receiver_pkg::*;
#(
   parameter int DEPTH  = DEPTH_DEF,
   parameter int ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  cell_t             wdata,
   input  logic [ADDR_W-1:0] raddr,
   output cell_t             rdata
);

   cell_t mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/path_receiver.sv
// Consumer end of the solver path handshake: requests the path after the goal is hit,
// buffers each strobed cell, then replays the path on a valid/ready stream.
//
//   state      | meaning
//   -----------+----------------------------------------------------------
//   ST_IDLE    | waiting for the_end; counters cleared on its acceptance
//   ST_REQ     | run raised, no cell captured yet
//   ST_COLLECT | capturing cells on load until done
//   ST_DRAIN   | replaying buffered cells downstream
module path_receiver
   import path_receiver_pkg::*;
#(
   parameter int DEPTH = DEPTH_DEF,
   parameter int LEN_W = $clog2(DEPTH) + 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  the_end,
   input  logic                  load,
   input  cell_t                 path_cell,
   input  logic                  done,
   output logic                  run,
   path_receiver_if.master       out_if,
   output logic                  busy,
   output logic [LEN_W-1:0]      path_len,
   output logic                  overflow
);

   localparam int PTR_W = LEN_W - 1;

   rx_state_t        state, state_nxt;
   logic [PTR_W-1:0] wr_ptr, rd_ptr;
   logic             full, capture, collecting, beat, last;
   cell_t            rd_cell;

   assign full       = (path_len == LEN_W'(DEPTH));
   assign collecting = (state == ST_REQ) || (state == ST_COLLECT);
   assign capture    = collecting && load && !full;
   assign last       = ({1'b0, rd_ptr} == (path_len - LEN_W'(1)));
   assign beat       = (state == ST_DRAIN) && out_if.out_ready;

   path_receiver_buffer #(
      .DEPTH  (DEPTH),
      .ADDR_W (PTR_W)
   ) u_buffer (
      .clk   (clk),
      .we    (capture),
      .waddr (wr_ptr),
      .wdata (path_cell),
      .raddr (rd_ptr),
      .rdata (rd_cell)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= ST_IDLE;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         path_len <= '0;
         overflow <= 1'b0;
      end else begin
         state <= state_nxt;
         if (state == ST_IDLE && the_end) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            path_len <= '0;
            overflow <= 1'b0;
         end
         if (capture) begin
            wr_ptr   <= wr_ptr + PTR_W'(1);
            path_len <= path_len + LEN_W'(1);
         end
         // a load against a full buffer is dropped but remembered until the next path
         if (collecting && load && full) begin
            overflow <= 1'b1;
         end
         if (state == ST_REQ && done && !load) begin
            path_len <= '0;
         end
         if (beat) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
      end
   end

   always_comb begin
      state_nxt        = state;
      run              = 1'b0;
      out_if.out_valid = 1'b0;
      out_if.out_cell  = '0;
      out_if.out_last  = 1'b0;
      busy             = (state != ST_IDLE);
      unique case (state)
         ST_IDLE: begin
            if (the_end) state_nxt = ST_REQ;
         end
         ST_REQ: begin
            run = 1'b1;
            if (load)      state_nxt = done ? ST_DRAIN : ST_COLLECT;
            else if (done) state_nxt = ST_IDLE;
         end
         ST_COLLECT: begin
            run = 1'b1;
            if (done) state_nxt = ST_DRAIN;
         end
         ST_DRAIN: begin
            out_if.out_valid = 1'b1;
            out_if.out_cell  = rd_cell;
            out_if.out_last  = last;
            if (beat && last) state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

endmodule

// File: tb/tb_path_receiver.sv
// Directed bench for path_receiver with a 4-entry buffer so overflow is reachable.
module tb_path_receiver;
   import path_receiver_pkg::*;

   localparam int DEPTH = 4;
   localparam int LEN_W = $clog2(DEPTH) + 1;

   logic             clk;
   logic             rst;
   logic             the_end;
   logic             load;
   cell_t            path_cell;
   logic             done;
   logic             run;
   logic             busy;
   logic [LEN_W-1:0] path_len;
   logic             overflow;

   int n_asserts = 0;
   int n_fail    = 0;

   path_receiver_if out_if ();

   path_receiver #(
      .DEPTH (DEPTH),
      .LEN_W (LEN_W)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .the_end   (the_end),
      .load      (load),
      .path_cell (path_cell),
      .done      (done),
      .run       (run),
      .out_if    (out_if),
      .busy      (busy),
      .path_len  (path_len),
      .overflow  (overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_asserts++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired observed=running expected=finished");
      $fatal(1, "watchdog");
   end

   logic [7:0]  nom [4];
   logic [7:0]  ovf [6];
   logic [15:0] rdy_pat;
   int          idx;

   initial begin
      nom     = '{8'h00, 8'h01, 8'h11, 8'h12};
      ovf     = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26};
      rdy_pat = 16'h0149;
      rst = 1'b0; the_end = 1'b0; load = 1'b0; path_cell = '0; done = 1'b0;
      out_if.out_ready = 1'b0;
      #2;
      chk("rst_run",      32'(run), 0);
      chk("rst_busy",     32'(busy), 0);
      chk("rst_valid",    32'(out_if.out_valid), 0);
      chk("rst_last",     32'(out_if.out_last), 0);
      chk("rst_cell",     32'(out_if.out_cell), 0);
      chk("rst_len",      32'(path_len), 0);
      chk("rst_overflow", 32'(overflow), 0);
      step(); step();
      rst = 1'b1;
      step();

      // load/done in IDLE are ignored
      load = 1'b1; path_cell = 8'h77; done = 1'b1;
      step();
      load = 1'b0; done = 1'b0;
      chk("idle_ignore_busy", 32'(busy), 0);
      chk("idle_ignore_len",  32'(path_len), 0);

      // nominal path, drain without backpressure
      the_end = 1'b1;
      step();
      the_end = 1'b0;
      chk("nom_run",  32'(run), 1);
      chk("nom_busy", 32'(busy), 1);
      chk("nom_len0", 32'(path_len), 0);
      for (int i = 0; i < 4; i++) begin
         load = 1'b1; path_cell = nom[i];
         step();
         chk("nom_len", 32'(path_len), 32'(i + 1));
      end
      load = 1'b0;
      chk("nom_no_early_valid", 32'(out_if.out_valid), 0);
      chk("nom_full_no_ovf",    32'(overflow), 0);
      done = 1'b1; out_if.out_ready = 1'b1;
      step();
      done = 1'b0;
      chk("nom_run_drop", 32'(run), 0);
      for (int i = 0; i < 4; i++) begin
         chk("nom_valid", 32'(out_if.out_valid), 1);
         chk("nom_cell",  32'(out_if.out_cell), 32'(nom[i]));
         chk("nom_last",  32'(out_if.out_last), (i == 3) ? 1 : 0);
         step();
      end
      chk("nom_end_valid", 32'(out_if.out_valid), 0);
      chk("nom_end_busy",  32'(busy), 0);
      chk("nom_end_len",   32'(path_len), 4);

      // same path, drain under backpressure
      out_if.out_ready = 1'b0;
      the_end = 1'b1;
      step();
      the_end = 1'b0;
      for (int i = 0; i < 4; i++) begin
         load = 1'b1; path_cell = nom[i];
         step();
      end
      load = 1'b0; done = 1'b1;
      step();
      done = 1'b0;
      idx = 0;
      for (int i = 0; i < 16 && idx < 4; i++) begin
         chk("bp_valid", 32'(out_if.out_valid), 1);
         chk("bp_cell",  32'(out_if.out_cell), 32'(nom[idx]));
         chk("bp_last",  32'(out_if.out_last), (idx == 3) ? 1 : 0);
         out_if.out_ready = rdy_pat[i];
         step();
         if (rdy_pat[i]) idx++;
      end
      out_if.out_ready = 1'b0;
      chk("bp_beats",     32'(idx), 4);
      chk("bp_end_valid", 32'(out_if.out_valid), 0);
      chk("bp_end_busy",  32'(busy), 0);

      // empty path
      the_end = 1'b1;
      step();
      the_end = 1'b0;
      chk("empty_run", 32'(run), 1);
      chk("empty_len_cleared", 32'(path_len), 0);
      done = 1'b1;
      step();
      done = 1'b0;
      chk("empty_run_drop", 32'(run), 0);
      chk("empty_busy",     32'(busy), 0);
      chk("empty_len",      32'(path_len), 0);
      chk("empty_valid",    32'(out_if.out_valid), 0);
      step();
      chk("empty_valid2",   32'(out_if.out_valid), 0);

      // overflow: six loads into a four-entry buffer
      the_end = 1'b1;
      step();
      the_end = 1'b0;
      for (int i = 0; i < 6; i++) begin
         load = 1'b1; path_cell = ovf[i];
         step();
      end
      load = 1'b0;
      chk("ovf_flag", 32'(overflow), 1);
      chk("ovf_len",  32'(path_len), 4);
      done = 1'b1; out_if.out_ready = 1'b1;
      step();
      done = 1'b0;
      for (int i = 0; i < 4; i++) begin
         chk("ovf_valid", 32'(out_if.out_valid), 1);
         chk("ovf_cell",  32'(out_if.out_cell), 32'(ovf[i]));
         chk("ovf_last",  32'(out_if.out_last), (i == 3) ? 1 : 0);
         step();
      end
      chk("ovf_end_valid", 32'(out_if.out_valid), 0);
      chk("ovf_sticky",    32'(overflow), 1);
      the_end = 1'b1;
      step();
      the_end = 1'b0;
      chk("ovf_cleared",  32'(overflow), 0);
      chk("ovf_len_clr",  32'(path_len), 0);

      // load and done together in REQ, the_end ignored during drain
      out_if.out_ready = 1'b0;
      load = 1'b1; done = 1'b1; path_cell = 8'h33;
      step();
      load = 1'b0; done = 1'b0;
      chk("same_len",   32'(path_len), 1);
      chk("same_valid", 32'(out_if.out_valid), 1);
      chk("same_cell",  32'(out_if.out_cell), 32'h33);
      chk("same_last",  32'(out_if.out_last), 1);
      the_end = 1'b1;
      step();
      the_end = 1'b0;
      chk("same_hold_valid", 32'(out_if.out_valid), 1);
      chk("same_hold_cell",  32'(out_if.out_cell), 32'h33);
      chk("same_hold_len",   32'(path_len), 1);
      out_if.out_ready = 1'b1;
      step();
      out_if.out_ready = 1'b0;
      chk("same_end_busy",  32'(busy), 0);
      chk("same_end_valid", 32'(out_if.out_valid), 0);

      // asynchronous reset in the middle of collection
      the_end = 1'b1;
      step();
      the_end = 1'b0;
      load = 1'b1; path_cell = 8'h40;
      step();
      path_cell = 8'h41;
      step();
      chk("mid_busy_before", 32'(busy), 1);
      chk("mid_len_before",  32'(path_len), 2);
      rst = 1'b0;
      #1;
      chk("mid_rst_run",  32'(run), 0);
      chk("mid_rst_busy", 32'(busy), 0);
      chk("mid_rst_len",  32'(path_len), 0);
      chk("mid_rst_valid", 32'(out_if.out_valid), 0);
      #2;
      rst = 1'b1;
      path_cell = 8'h55;
      step();
      load = 1'b0;
      chk("post_rst_busy", 32'(busy), 0);
      chk("post_rst_len",  32'(path_len), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
      $finish;
   end

endmodule
